// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, one write port
// and a per-register pending scoreboard. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_pendSet,
    input  logic [ADDR_WIDTH-1:0] ctrl_pendReg,
    output logic                  pend_readRegA,
    output logic                  pend_readRegB,
    output logic [ADDR_WIDTH:0]   pend_count,
    output logic                  pend_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic [DEPTH-1:0]      w_pend_next;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_err;

    logic w_wr_en;
    logic w_set_en;
    logic w_same_idx;
    logic w_inc;
    logic w_dec;
    logic w_dup_set;

    // Index 0 is inert when hardwired: writes and pending sets on it vanish here.
    assign w_wr_en    = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    assign w_set_en   = ctrl_pendSet && !((ZERO_REG != 0) && (ctrl_pendReg == '0));
    assign w_same_idx = (ctrl_writeReg == ctrl_pendReg);

    // A set on the register being written wins, so that write must not also decrement.
    assign w_inc     = w_set_en && !r_pend[ctrl_pendReg];
    assign w_dec     = w_wr_en && r_pend[ctrl_writeReg] && !(w_set_en && w_same_idx);
    assign w_dup_set = w_set_en && r_pend[ctrl_pendReg] && !(w_wr_en && w_same_idx);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clock or posedge ctrl_reset) begin
                if (ctrl_reset) begin
                    r_regs[gi] <= '0;
                end else if (w_wr_en && (ctrl_writeReg == ADDR_WIDTH'(gi))) begin
                    r_regs[gi] <= data_writeReg;
                end
            end

            assign w_pend_next[gi] =
                (w_set_en && (ctrl_pendReg == ADDR_WIDTH'(gi))) ? 1'b1 :
                (w_wr_en && (ctrl_writeReg == ADDR_WIDTH'(gi))) ? 1'b0 :
                r_pend[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_pend  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pend  <= w_pend_next;
            r_count <= r_count + (ADDR_WIDTH+1)'(w_inc) - (ADDR_WIDTH+1)'(w_dec);
            if (w_dup_set) begin
                r_err <= 1'b1;
            end
        end
    end

    logic [ADDR_WIDTH-1:0] w_raddr [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic                  w_rpend [2];

    assign w_raddr[0] = ctrl_readRegA;
    assign w_raddr[1] = ctrl_readRegB;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                w_rdata[gi] = r_regs[w_raddr[gi]];
                w_rpend[gi] = r_pend[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
                // Forward the retiring result; a same-cycle re-issue keeps it pending.
                if (w_wr_en && (w_raddr[gi] == ctrl_writeReg)) begin
                    w_rdata[gi] = data_writeReg;
                    w_rpend[gi] = w_set_en && (ctrl_pendReg == w_raddr[gi]);
                end
`endif
                if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
                    w_rdata[gi] = '0;
                    w_rpend[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign data_readRegA = w_rdata[0];
    assign data_readRegB = w_rdata[1];
    assign pend_readRegA = w_rpend[0];
    assign pend_readRegB = w_rpend[1];
    assign pend_count    = r_count;
    assign pend_err      = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default parameters); expectations
// follow the build's REGFILE_BYPASS_EN setting.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] da;
    logic [31:0] db;
    logic        pset;
    logic [4:0]  preg;
    logic        pa;
    logic        pb;
    logic [5:0]  pcount;
    logic        perr;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clock            (clk),
        .ctrl_reset       (rst),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdata),
        .ctrl_readRegA    (ra),
        .ctrl_readRegB    (rb),
        .data_readRegA    (da),
        .data_readRegB    (db),
        .ctrl_pendSet     (pset),
        .ctrl_pendReg     (preg),
        .pend_readRegA    (pa),
        .pend_readRegB    (pb),
        .pend_count       (pcount),
        .pend_err         (perr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wreg = '0; wdata = '0; ra = '0; rb = '0; pset = 1'b0; preg = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset_count", 32'(pcount), 32'd0);
        check("reset_err", 32'(perr), 32'd0);
        check("reset_readA0", da, 32'h0);

        // Write reg5, set reg2 pending, then duplicate set on reg2 for an error.
        we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; pset = 1'b1; preg = 5'd2;
        tick();
        we = 1'b0;
        tick();
        pset = 1'b0; ra = 5'd5; rb = 5'd2;
        #1;
        check("pre_rst_readA5", da, 32'hDEADBEEF);
        check("pre_rst_count", 32'(pcount), 32'd1);
        check("pre_rst_pendB2", 32'(pb), 32'd1);
        check("pre_rst_err", 32'(perr), 32'd1);
        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_readA5", da, 32'h0);
        check("async_rst_count", 32'(pcount), 32'd0);
        check("async_rst_err", 32'(perr), 32'd0);
        check("async_rst_pendB2", 32'(pb), 32'd0);
        rst = 1'b0;

        // Write/read and register 0 hardwired.
        tick();
        we = 1'b1; wreg = 5'd7; wdata = 32'h12345678;
        tick();
        we = 1'b0; ra = 5'd7; rb = 5'd0;
        #1;
        check("rd_A7", da, 32'h12345678);
        check("rd_B0", db, 32'h0);
        we = 1'b1; wreg = 5'd0; wdata = 32'hFFFFFFFF;
        tick();
        we = 1'b0;
        #1;
        check("rd_B0_after_write", db, 32'h0);

        // Same-cycle write/read of reg9.
        we = 1'b1; wreg = 5'd9; wdata = 32'hA5A5A5A5; ra = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_A9", da, 32'hA5A5A5A5);
`else
        check("bypass_A9", da, 32'h0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("after_A9", da, 32'hA5A5A5A5);

        // Scoreboard set/clear.
        pset = 1'b1; preg = 5'd3;
        tick();
        preg = 5'd4;
        tick();
        pset = 1'b0; ra = 5'd3;
        #1;
        check("sb_count2", 32'(pcount), 32'd2);
        check("sb_pendA3", 32'(pa), 32'd1);
        we = 1'b1; wreg = 5'd3; wdata = 32'h33;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_pendA3_bypass", 32'(pa), 32'd0);
`else
        check("sb_pendA3_bypass", 32'(pa), 32'd1);
`endif
        tick();
        we = 1'b0;
        #1;
        check("sb_count1", 32'(pcount), 32'd1);
        check("sb_pendA3_clr", 32'(pa), 32'd0);

        // Pending {4,6}; then set and write reg6 together.
        pset = 1'b1; preg = 5'd6;
        tick();
        we = 1'b1; wreg = 5'd6; wdata = 32'h66; ra = 5'd6;
        #1;
        check("sw6_pendA_same", 32'(pa), 32'd1);
        tick();
        pset = 1'b0; we = 1'b0;
        #1;
        check("sw6_pendA6", 32'(pa), 32'd1);
        check("sw6_count", 32'(pcount), 32'd2);
        check("sw6_err", 32'(perr), 32'd0);
        check("sw6_data", da, 32'h66);

        // Duplicate set on reg4 with no write: sticky error.
        pset = 1'b1; preg = 5'd4;
        tick();
        pset = 1'b0;
        #1;
        check("dup4_err", 32'(perr), 32'd1);
        check("dup4_count", 32'(pcount), 32'd2);
        tick();
        check("dup4_err_sticky", 32'(perr), 32'd1);

        // Set reg8 while writing pending reg4: count unchanged.
        pset = 1'b1; preg = 5'd8; we = 1'b1; wreg = 5'd4; wdata = 32'h44;
        tick();
        pset = 1'b0; we = 1'b0; ra = 5'd4; rb = 5'd8;
        #1;
        check("diff_count", 32'(pcount), 32'd2);
        check("diff_pendA4", 32'(pa), 32'd0);
        check("diff_pendB8", 32'(pb), 32'd1);
        check("diff_err_sticky", 32'(perr), 32'd1);

        // Reset, then fill every nonzero register.
        rst = 1'b1;
        #1;
        check("rst2_err", 32'(perr), 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            pset = 1'b1; preg = 5'(i);
            tick();
        end
        pset = 1'b0;
        #1;
        check("fill_count31", 32'(pcount), 32'd31);
        check("fill_err", 32'(perr), 32'd0);
        pset = 1'b1; preg = 5'd0;
        tick();
        pset = 1'b0; ra = 5'd31; rb = 5'd0;
        #1;
        check("fill_set0_count", 32'(pcount), 32'd31);
        check("fill_set0_err", 32'(perr), 32'd0);
        check("fill_pendA31", 32'(pa), 32'd1);
        check("fill_pendB0", 32'(pb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
